cb_deseg: RTL
=============

CB_DESEG -- requirements
Module: cb_deseg

Interface
REQ-001 SHALL have parameter K_PLUS_BYTES, default 768: total bytes (filler + data + CRC) of a large code block.
REQ-002 SHALL have parameter K_MINUS_BYTES, default 760: total bytes of a small code block.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cb_valid  input  1  input byte strobe; no backpressure, the block always accepts it.
REQ-006 SHALL have port cb_data  input  8  received code-block byte.
REQ-007 SHALL have port start  input  1  qualifies the first byte of a code block.
REQ-008 SHALL have port filling  input  1  qualifies a filler byte.
REQ-009 SHALL have port crc  input  1  qualifies a CRC24B byte, MSB byte first.
REQ-010 SHALL have port cb_size  input  1  block size: 1 = K_PLUS_BYTES, 0 = K_MINUS_BYTES; sampled with start.
REQ-011 SHALL have port tb_valid  output  1  tb_out holds a payload byte.
REQ-012 SHALL have port tb_out  output  8  reassembled transport-block byte.
REQ-013 SHALL have port cb_done  output  1  one-cycle pulse at the end of a code block.
REQ-014 SHALL have port cb_crc_ok  output  1  CRC result; meaningful only while cb_done is high.
REQ-015 SHALL have port cb_err  output  1  one-cycle protocol-error pulse.

Function
REQ-016 SHALL implement states IDLE, BODY, CRC0, CRC1, CRC2 and DONE.
REQ-017 IDLE: cb_valid&start SHALL clear the CRC, latch cb_size, load byte count 1, process the byte as filler or data, and go to BODY; cb_valid without start SHALL pulse cb_err and drop the byte.
REQ-018 BODY: filler bytes SHALL update the CRC and produce no output; data bytes SHALL update the CRC and produce tb_valid=1 with tb_out=cb_data one cycle later.
REQ-019 A byte with crc=1 in BODY SHALL freeze the computed remainder, store the byte as received bits [23:16], and go to CRC0.
REQ-020 CRC0/CRC1 SHALL store the next byte as received bits [15:8]/[7:0] respectively; the third CRC byte SHALL move the FSM to DONE.
REQ-021 DONE SHALL last exactly one cycle, drive cb_done=1 and cb_crc_ok=(received==computed), then return to IDLE; a start byte arriving in DONE SHALL be taken as in IDLE.
REQ-022 The CRC SHALL be CRC24B, polynomial 0x800063, initial value 0, 8 bits processed per cycle MSB first, with no final XOR.
REQ-023 start asserted in any state other than IDLE/DONE SHALL pulse cb_err, abandon the current block without cb_done, and restart as in REQ-017 in the same cycle.
REQ-024 In CRC0/CRC1 a byte without crc=1 SHALL pulse cb_err and return the FSM to IDLE.
REQ-025 filling and crc both high SHALL be treated as crc; filling after the first data byte of a block SHALL pulse cb_err and the byte SHALL be dropped.
REQ-026 Cycles without cb_valid SHALL hold all state; tb_valid, cb_done and cb_err SHALL be low on those cycles unless a pulse is already due.
REQ-027 The output latency SHALL be exactly 1 cycle from the accepting edge; outputs SHALL be registered.

Reset
REQ-028 reset SHALL force IDLE, CRC=0, counters=0, and tb_valid=0, tb_out=0x00, cb_done=0, cb_crc_ok=0, cb_err=0 immediately; a block in progress SHALL be discarded without cb_done.

Configuration
REQ-029 With CB_DESEG_LEN_CHECK_EN defined, a 16-bit byte counter SHALL run; in DONE, a count differing from the selected K_*_BYTES SHALL force cb_crc_ok=0 and pulse cb_err alongside cb_done. A count reaching the size while still in BODY SHALL pulse cb_err and return the FSM to IDLE.
REQ-030 Without CB_DESEG_LEN_CHECK_EN, no counter SHALL exist and cb_size SHALL be ignored.

Structure
REQ-031 The shared package SHALL hold the state enum, CRC24B_POLY = 24'h800063 and CRC_BYTES = 3.
REQ-032 One sub-module, crc24b_byte, SHALL provide the combinational 8-bit-per-step CRC24B next-state function; the FSM and registers SHALL stay in cb_deseg.

Verification
REQ-033 Large block (cb_size=1): 4 filler bytes 0x00, 761 data bytes 0x01..., and the model's 3 CRC bytes -> 761 tb_valid pulses with matching data, then cb_done=1, cb_crc_ok=1, cb_err=0.
REQ-034 Same block with data byte 100 corrupted to 0xFF -> payload passes through, then cb_done=1, cb_crc_ok=0.
REQ-035 start reasserted at byte 50 of a block -> cb_err pulses once; the new block completes with cb_crc_ok=1; the first block gets no cb_done.
REQ-036 With CB_DESEG_LEN_CHECK_EN and cb_size=0, a 759-byte block with valid CRC -> cb_done=1, cb_crc_ok=0, cb_err=1.
REQ-037 reset asserted mid-CRC1, then a valid K_MINUS block -> all outputs 0 during reset; afterwards the new block gives cb_crc_ok=1.
REQ-038 cb_valid toggled randomly at 50% over a valid block -> results identical to REQ-033.

Source files
------------

// File: rtl/cb_deseg_pkg.sv
// Shared types and constants for the code-block de-segmenter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cb_deseg_pkg;

  // CRC2 is kept in the encoding but never entered: the third CRC byte is consumed in CRC1.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BODY = 3'd1,
    CRC0 = 3'd2,
    CRC1 = 3'd3,
    CRC2 = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [23:0] CRC24B_POLY = 24'h800063;
  localparam int unsigned CRC_BYTES   = 3;

endpackage

// File: rtl/cb_deseg_crc.sv
// CRC24B next-state for one byte, MSB first, no reflection.
// Latency: combinational.
// Backpressure: n/a.
module crc24b_byte
  import cb_deseg_pkg::*;
(
  input  logic [23:0] crc_in,
  input  logic [7:0]  dat,
  output logic [23:0] crc_out
);

  logic [23:0] c;

  // Eight serial LFSR steps unrolled, data bit 7 first.
  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[23] ^ dat[i]) c = {c[22:0], 1'b0} ^ CRC24B_POLY;
      else                c = {c[22:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/cb_deseg.sv
// Strips filler and CRC24B from a received code block, streams payload bytes, reports CRC status.
// Latency: 1 cycle from the accepting edge; all outputs registered. Optional length check: CB_DESEG_LEN_CHECK_EN.
// Backpressure: none; every cb_valid byte is accepted, idle cycles hold state.
module cb_deseg
  import cb_deseg_pkg::*;
#(
  parameter int K_PLUS_BYTES  = 768,
  parameter int K_MINUS_BYTES = 760
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cb_valid,
  input  logic [7:0] cb_data,
  input  logic       start,
  input  logic       filling,
  input  logic       crc,
  input  logic       cb_size,
  output logic       tb_valid,
  output logic [7:0] tb_out,
  output logic       cb_done,
  output logic       cb_crc_ok,
  output logic       cb_err
);

  state_t      state;
  logic [23:0] crc_q;
  logic [23:0] rx_q;
  logic [23:0] crc_seed;
  logic [23:0] crc_upd;
  logic        seen_data;
  logic        take_start;
  logic        in_block;
  logic        len_full;
  logic        len_bad;

  assign take_start = cb_valid & start;
  assign in_block   = (state == BODY) | (state == CRC0) | (state == CRC1);
  // A start byte restarts the remainder from zero in the same cycle.
  assign crc_seed   = take_start ? 24'h0 : crc_q;

  crc24b_byte u_crc (
    .crc_in  (crc_seed),
    .dat     (cb_data),
    .crc_out (crc_upd)
  );

`ifdef CB_DESEG_LEN_CHECK_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic [15:0] k_sel;
  logic        size_q;
  logic        take_cnt;

  assign k_sel    = size_q ? 16'(K_PLUS_BYTES) : 16'(K_MINUS_BYTES);
  assign cnt_inc  = cnt_q + 16'd1;
  // Counted bytes: everything the FSM accepts into the block; dropped late fillers are not counted.
  assign take_cnt = cb_valid & ~start &
                    (((state == BODY) & (crc | ~filling | ~seen_data)) |
                     (((state == CRC0) | (state == CRC1)) & crc));
  assign len_full = (cnt_inc == k_sel);
  assign len_bad  = (cnt_inc != k_sel);

  // Byte counter and latched block size for the length check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 16'd0;
      size_q <= 1'b0;
    end else if (take_start) begin
      cnt_q  <= 16'd1;
      size_q <= cb_size;
    end else if (take_cnt) begin
      cnt_q  <= cnt_inc;
    end
  end
`else
  logic unused_size;
  assign unused_size = cb_size;
  assign len_full    = 1'b0;
  assign len_bad     = 1'b0;
`endif

  // Main FSM with registered payload, done, CRC status and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      crc_q     <= 24'h0;
      rx_q      <= 24'h0;
      seen_data <= 1'b0;
      tb_valid  <= 1'b0;
      tb_out    <= 8'h00;
      cb_done   <= 1'b0;
      cb_crc_ok <= 1'b0;
      cb_err    <= 1'b0;
    end else begin
      tb_valid  <= 1'b0;
      cb_done   <= 1'b0;
      cb_crc_ok <= 1'b0;
      cb_err    <= 1'b0;
      if ((state == DONE) || (state == CRC2)) state <= IDLE;

      if (take_start) begin
        // Start mid-block abandons the old block silently apart from the error pulse.
        cb_err <= in_block;
        crc_q  <= crc_upd;
        state  <= BODY;
        if (filling | crc) begin
          seen_data <= 1'b0;
        end else begin
          seen_data <= 1'b1;
          tb_valid  <= 1'b1;
          tb_out    <= cb_data;
        end
      end else if (cb_valid) begin
        case (state)
          BODY: begin
            if (crc) begin
              rx_q[23:16] <= cb_data;
              state       <= CRC0;
            end else if (filling & seen_data) begin
              cb_err <= 1'b1;
            end else if (len_full) begin
              cb_err <= 1'b1;
              state  <= IDLE;
            end else begin
              crc_q <= crc_upd;
              if (!filling) begin
                seen_data <= 1'b1;
                tb_valid  <= 1'b1;
                tb_out    <= cb_data;
              end
            end
          end
          CRC0: begin
            if (crc) begin
              rx_q[15:8] <= cb_data;
              state      <= CRC1;
            end else begin
              cb_err <= 1'b1;
              state  <= IDLE;
            end
          end
          CRC1: begin
            if (crc) begin
              rx_q[7:0] <= cb_data;
              state     <= DONE;
              cb_done   <= 1'b1;
              cb_crc_ok <= ({rx_q[23:8], cb_data} == crc_q) & ~len_bad;
              cb_err    <= len_bad;
            end else begin
              cb_err <= 1'b1;
              state  <= IDLE;
            end
          end
          default: cb_err <= 1'b1;
        endcase
      end
    end
  end

endmodule
